// File: rtl/DataTypes.sv
// Shared types and default sizes for the UART-to-processor FIFO read side.
package DataTypes;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int ADDR_W          = FIFO_ADDR_WIDTH + 1;

    typedef logic              bit_t;
    typedef logic [ADDR_W-1:0] ptr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } rd_state_t;

endpackage

// File: rtl/fifo_fill_calc.sv
// Wrap-safe occupancy from a pair of binary pointers carrying an extra wrap bit.
module fifo_fill_calc #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic [ADDR_WIDTH:0] i_w_ptr,
    input  logic [ADDR_WIDTH:0] i_r_ptr,
    output logic [ADDR_WIDTH:0] o_fill_level,
    output logic                o_empty,
    output logic                o_overflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0] w_fill;

    // Modulo 2**(ADDR_WIDTH+1) subtraction; a full FIFO yields exactly DEPTH.
    assign w_fill       = i_w_ptr - i_r_ptr;
    assign o_fill_level = w_fill;
    assign o_empty      = (w_fill == '0);
    assign o_overflow   = (w_fill > DEPTH);

endmodule

// File: rtl/uart_rx_fifo_read_ctrl.sv
// Processor-side FIFO read controller: owns r_ptr, sequences RAM reads, presents words over valid/ready.
module uart_rx_fifo_read_ctrl
    import DataTypes::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH:0]   w_ptr_sync,
    output logic [ADDR_WIDTH:0]   r_ptr,
    output logic                  mem_r_en,
    output logic [ADDR_WIDTH-1:0] mem_r_add,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  fifo_empty,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  ptr_err
);

    rd_state_t             r_state;
    rd_state_t             w_next_state;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_err;
    logic                  w_empty;
    logic                  w_overflow;
    logic                  w_can_fetch;
    logic [ADDR_WIDTH:0]   w_fill;

    fifo_fill_calc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fill (
        .i_w_ptr      (w_ptr_sync),
        .i_r_ptr      (r_rd_ptr),
        .o_fill_level (w_fill),
        .o_empty      (w_empty),
        .o_overflow   (w_overflow)
    );

    // Inconsistent pointers also block a fetch in the same cycle the error is first seen.
    assign w_can_fetch = !w_empty && !r_err && !w_overflow;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_can_fetch) w_next_state = FETCH;
            FETCH:   w_next_state = CAPTURE;
            CAPTURE: w_next_state = HOLD;
            HOLD:    if (data_ready) w_next_state = w_can_fetch ? FETCH : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rd_ptr <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Natural wrap of the extra bit toggles the MSB when the low bits roll over.
            if (r_state == FETCH) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (r_state == CAPTURE) begin
                r_data  <= mem_r_data;
                r_valid <= 1'b1;
            end else if (r_state == HOLD && data_ready) begin
                r_valid <= 1'b0;
            end
            if (w_overflow) r_err <= 1'b1;
        end
    end

    assign mem_r_en   = (r_state == FETCH);
    assign mem_r_add  = r_rd_ptr[ADDR_WIDTH-1:0];
    assign r_ptr      = r_rd_ptr;
    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign fifo_empty = w_empty;
    assign fill_level = w_fill;
    assign ptr_err    = r_err;

endmodule

// File: tb/tb_uart_rx_fifo_read_ctrl.sv
// Self-checking bench for uart_rx_fifo_read_ctrl: vector table, corner sequences, randomized scoreboard.
module tb_uart_rx_fifo_read_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW:0]   w_ptr_sync;
    logic [AW:0]   r_ptr;
    logic          mem_r_en;
    logic [AW-1:0] mem_r_add;
    logic [DW-1:0] mem_r_data = '0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready;
    logic          fifo_empty;
    logic [AW:0]   fill_level;
    logic          ptr_err;

    logic [DW-1:0] ram [DEPTH];
    int n_cmp  = 0;
    int n_fail = 0;
    int got_q[$];
    int add_q[$];

    typedef struct {
        logic [AW:0]   w;
        logic          rdy;
        logic          en;
        logic [AW-1:0] add;
        logic          vld;
        logic [DW-1:0] dat;
        logic [AW:0]   rp;
        logic          emp;
    } vec_t;

    vec_t tbl[6];

    uart_rx_fifo_read_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .w_ptr_sync (w_ptr_sync),
        .r_ptr      (r_ptr),
        .mem_r_en   (mem_r_en),
        .mem_r_add  (mem_r_add),
        .mem_r_data (mem_r_data),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .fifo_empty (fifo_empty),
        .fill_level (fill_level),
        .ptr_err    (ptr_err)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears the cycle after mem_r_en.
    always @(posedge clk) if (mem_r_en) mem_r_data <= ram[mem_r_add];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        w_ptr_sync = '0;
        data_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
    endtask

    task automatic collect(input int n, input int budget);
        int cyc = 0;
        got_q.delete();
        add_q.delete();
        while (got_q.size() < n && cyc < budget) begin
            if (mem_r_en) add_q.push_back(int'(mem_r_add));
            if (data_valid && data_ready) got_q.push_back(int'(data_out));
            tick();
            cyc++;
        end
    endtask

    function automatic int got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : -1;
    endfunction

    function automatic int add_at(input int i);
        return (i < add_q.size()) ? add_q[i] : -1;
    endfunction

    initial begin
        int cnt;
        int wr;
        int fcnt;
        int exp_q[$];
        int k;
        int cyc;

        //                w      rdy   en    add   vld   dat    rp     emp
        tbl[0] = '{5'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 5'd0, 1'b0};
        tbl[1] = '{5'd1, 1'b1, 1'b1, 4'd0, 1'b0, 8'h00, 5'd0, 1'b0};
        tbl[2] = '{5'd1, 1'b1, 1'b0, 4'd1, 1'b0, 8'h00, 5'd1, 1'b1};
        tbl[3] = '{5'd1, 1'b1, 1'b0, 4'd1, 1'b1, 8'hA5, 5'd1, 1'b1};
        tbl[4] = '{5'd1, 1'b1, 1'b0, 4'd1, 1'b0, 8'hA5, 5'd1, 1'b1};
        tbl[5] = '{5'd1, 1'b1, 1'b0, 4'd1, 1'b0, 8'hA5, 5'd1, 1'b1};

        for (int i = 0; i < DEPTH; i++) ram[i] = '0;

        // Reset values while reset is held
        reset = 1'b1; w_ptr_sync = '0; data_ready = 1'b0;
        #2;
        chk("rst_r_ptr", int'(r_ptr), 0);
        chk("rst_valid", int'(data_valid), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_en", int'(mem_r_en), 0);
        chk("rst_err", int'(ptr_err), 0);
        do_reset();

        // Empty FIFO for 20 cycles
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_r_en || data_valid || !fifo_empty) cnt++;
            tick();
        end
        chk("empty_idle_activity", cnt, 0);
        chk("empty_r_ptr", int'(r_ptr), 0);
        chk("empty_flag", int'(fifo_empty), 1);

        // Single word, cycle by cycle
        ram[0] = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            w_ptr_sync = tbl[i].w;
            data_ready = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d_en", i), int'(mem_r_en), int'(tbl[i].en));
            chk($sformatf("vec%0d_add", i), int'(mem_r_add), int'(tbl[i].add));
            chk($sformatf("vec%0d_vld", i), int'(data_valid), int'(tbl[i].vld));
            chk($sformatf("vec%0d_dat", i), int'(data_out), int'(tbl[i].dat));
            chk($sformatf("vec%0d_rp", i), int'(r_ptr), int'(tbl[i].rp));
            chk($sformatf("vec%0d_emp", i), int'(fifo_empty), int'(tbl[i].emp));
            tick();
        end

        // Backpressure: three words, processor stalls
        do_reset();
        ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33;
        w_ptr_sync = 5'd3;
        data_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mem_r_en) cnt++;
            tick();
        end
        chk("bp_en_pulses", cnt, 1);
        chk("bp_hold_data", int'(data_out), 8'h11);
        chk("bp_hold_valid", int'(data_valid), 1);
        chk("bp_fill", int'(fill_level), 2);
        data_ready = 1'b1;
        #1;
        collect(3, 40);
        chk("bp_count", got_q.size(), 3);
        chk("bp_word0", got_at(0), 8'h11);
        chk("bp_word1", got_at(1), 8'h22);
        chk("bp_word2", got_at(2), 8'h33);

        // Wrap-around: advance r_ptr to 0x0F, then read across the boundary
        do_reset();
        for (int i = 0; i < 15; i++) ram[i] = DW'(i + 8'h40);
        w_ptr_sync = 5'd15;
        data_ready = 1'b1;
        #1;
        collect(15, 100);
        chk("wrap_pre_count", got_q.size(), 15);
        chk("wrap_pre_rptr", int'(r_ptr), 5'h0F);
        ram[15] = 8'hAA; ram[0] = 8'hBB;
        w_ptr_sync = 5'h11;
        #1;
        chk("wrap_fill", int'(fill_level), 2);
        collect(2, 30);
        repeat (2) tick();
        chk("wrap_addr0", add_at(0), 15);
        chk("wrap_addr1", add_at(1), 0);
        chk("wrap_word0", got_at(0), 8'hAA);
        chk("wrap_word1", got_at(1), 8'hBB);
        chk("wrap_rptr", int'(r_ptr), 5'h11);
        chk("wrap_empty", int'(fifo_empty), 1);

        // Full FIFO is legal
        do_reset();
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i * 7 + 3);
        w_ptr_sync = 5'h10;
        #1;
        chk("full_fill", int'(fill_level), 16);
        tick();
        chk("full_err", int'(ptr_err), 0);
        data_ready = 1'b1;
        #1;
        collect(16, 100);
        chk("full_count", got_q.size(), 16);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("full_word%0d", i), got_at(i), (i * 7 + 3) & 8'hFF);
        chk("full_rptr", int'(r_ptr), 5'h10);
        chk("full_err_end", int'(ptr_err), 0);

        // Pointer error arriving while a word is held: word completes, nothing further fetched
        do_reset();
        ram[0] = 8'h5A;
        w_ptr_sync = 5'd1;
        repeat (3) tick();
        chk("err_hold_valid", int'(data_valid), 1);
        w_ptr_sync = 5'h14;
        #1;
        chk("err_fill", int'(fill_level), 19);
        tick();
        chk("err_set", int'(ptr_err), 1);
        chk("err_hold_data", int'(data_out), 8'h5A);
        data_ready = 1'b1;
        tick();
        chk("err_valid_drop", int'(data_valid), 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_r_en || data_valid) cnt++;
            tick();
        end
        chk("err_no_fetch", cnt, 0);
        chk("err_sticky", int'(ptr_err), 1);

        // Error straight from reset: no fetch at all
        do_reset();
        w_ptr_sync = 5'h14;
        tick();
        chk("err0_set", int'(ptr_err), 1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_r_en) cnt++;
            tick();
        end
        chk("err0_no_fetch", cnt, 0);

        // Asynchronous reset in the middle of HOLD with the error flag set
        do_reset();
        ram[0] = 8'h77;
        w_ptr_sync = 5'd1;
        repeat (3) tick();
        w_ptr_sync = 5'h14;
        tick();
        chk("rsth_pre_valid", int'(data_valid), 1);
        chk("rsth_pre_err", int'(ptr_err), 1);
        reset = 1'b1;
        #1;
        chk("rsth_valid", int'(data_valid), 0);
        chk("rsth_rptr", int'(r_ptr), 0);
        chk("rsth_err", int'(ptr_err), 0);
        chk("rsth_data", int'(data_out), 0);
        do_reset();

        // Randomized traffic against an ordered scoreboard
        wr = 0; fcnt = 0;
        exp_q.delete();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(2) == 0) begin
                k = int'($urandom_range(3, 1));
                for (int j = 0; j < k; j++) begin
                    if (wr - (fcnt - (data_valid ? 1 : 0)) < DEPTH && wr - fcnt < DEPTH) begin
                        ram[wr % DEPTH] = DW'($urandom);
                        exp_q.push_back(int'(ram[wr % DEPTH]));
                        wr++;
                    end
                end
            end
            w_ptr_sync = (AW+1)'(wr);
            data_ready = ($urandom_range(3) != 0);
            #1;
            chk("rnd_rptr", int'(r_ptr), fcnt % 32);
            chk("rnd_fill", int'(fill_level), (wr - fcnt) % 32);
            chk("rnd_empty", int'(fifo_empty), (wr == fcnt) ? 1 : 0);
            if (mem_r_en) begin
                chk("rnd_add", int'(mem_r_add), fcnt % DEPTH);
                fcnt++;
            end
            if (fcnt > wr) chk("rnd_underflow", fcnt, wr);
            if (data_valid && data_ready) begin
                chk("rnd_word", int'(data_out), (exp_q.size() > 0) ? exp_q.pop_front() : -1);
            end
            @(posedge clk);
            #1;
        end
        data_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            #1;
            if (mem_r_en) fcnt++;
            if (data_valid && data_ready) chk("rnd_drain_word", int'(data_out), exp_q.pop_front());
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_err", int'(ptr_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_read_ctrl.md
Name: uart_rx_fifo_read_ctrl

Overview:
Processor-clock-domain read controller for the UART-to-processor FIFO. It takes the write pointer already synchronized into the processor domain (binary, after gray/2FF/gray-to-bin), owns the read pointer, and sequences FIFO RAM reads. It delivers words to the processor over a valid/ready interface and exports the read pointer for synchronization back to the UART domain.

Parameters:
ADDR_WIDTH, 4, FIFO RAM address bits; depth DEPTH = 2**ADDR_WIDTH
DATA_WIDTH, 8, word width

Ports:
clk  in  1  processor clock
reset  in  1  asynchronous, active-high reset
w_ptr_sync  in  ADDR_WIDTH+1  synchronized binary write pointer; MSB is the wrap bit
r_ptr  out  ADDR_WIDTH+1  binary read pointer, registered; MSB is the wrap bit
mem_r_en  out  1  RAM read enable, one-cycle pulse
mem_r_add  out  ADDR_WIDTH  RAM read address, equal to r_ptr[ADDR_WIDTH-1:0]
mem_r_data  in  DATA_WIDTH  RAM read data, valid 1 cycle after mem_r_en
data_out  out  DATA_WIDTH  word presented to processor
data_valid  out  1  data_out valid
data_ready  in  1  processor accepts the word
fifo_empty  out  1  combinational: fill_level == 0
fill_level  out  ADDR_WIDTH+1  words available, not counting the held word
ptr_err  out  1  sticky pointer-inconsistency flag

Behaviour:
- Clocking and reset: single clock clk; reset is asynchronous and active-high.
- Reset values: r_ptr=0, data_out=0, data_valid=0, mem_r_en=0, ptr_err=0, state=IDLE.
- fill_level = (w_ptr_sync - r_ptr) mod 2**(ADDR_WIDTH+1); unsigned, wrap-safe.
- Error: if fill_level > DEPTH, set ptr_err on the next edge. It stays set until reset. While ptr_err=1, no new fetch starts. A word already in CAPTURE/HOLD completes normally.
- FSM states: IDLE, FETCH, CAPTURE, HOLD.
- IDLE: if !fifo_empty && !ptr_err, go to FETCH.
- FETCH (1 cycle):
  - mem_r_en=1, mem_r_add=r_ptr[ADDR_WIDTH-1:0].
  - r_ptr increments on exit; the MSB toggles when the low bits wrap from DEPTH-1 to 0.
  - Go to CAPTURE.
- CAPTURE (1 cycle): data_out <= mem_r_data; data_valid <= 1; go to HOLD.
- HOLD:
  - data_valid=1 and data_out is stable until the handshake.
  - On data_ready: data_valid drops next cycle. Go to FETCH if !fifo_empty && !ptr_err, else IDLE.
  - With data_ready held high and the FIFO non-empty, throughput is 1 word per 3 cycles.
- mem_r_en is 0 in every state except FETCH.
- Latency: a non-empty condition seen in IDLE at edge N gives data_valid=1 after edge N+3.
- r_ptr is updated only at the FETCH exit, so the UART side sees the slot freed as soon as it is read into the holding register.
- w_ptr_sync is treated as monotonic (it is stale by the synchronizer delay). A stale-low value only delays reads and never causes underflow, because empty is evaluated before each FETCH.
- If reset asserts mid-transfer, all state clears immediately. The held word is discarded (the write side is reset too).
- Full: fill_level == DEPTH is legal (MSBs differ, low bits equal). The controller reads normally.

Decomposition:
- Package DataTypes holds:
  - bit_t and ADDR_W, with ADDR_W sized ADDR_WIDTH+1.
  - FIFO_ADDR_WIDTH and FIFO_DATA_WIDTH constants.
  - enum rd_state_t {IDLE, FETCH, CAPTURE, HOLD}.
- Sub-module fifo_fill_calc: combinational; computes fill_level, fifo_empty and the overflow-inconsistency condition from w_ptr_sync and r_ptr. It is reusable on the write side for a full flag.
- The FSM and the pointer register stay in the top module.

Test Plan:
- Empty at reset: w_ptr_sync=0 for 20 cycles -> mem_r_en never asserts, data_valid=0, fifo_empty=1, r_ptr=0.
- Single word: RAM[0]=8'hA5, w_ptr_sync 0->1 at edge N -> mem_r_en=1 and mem_r_add=0 in cycle N+1. data_valid=1 and data_out=8'hA5 after edge N+3. r_ptr=1. With data_ready=1 held: data_valid=0 next cycle, state IDLE.
- Backpressure: 3 words 8'h11/8'h22/8'h33 with data_ready=0 for 10 cycles -> data_out stays 8'h11, only one mem_r_en pulse, fill_level=2. Releasing data_ready then drains 8'h22 and 8'h33 in order.
- Wrap-around (ADDR_WIDTH=4): r_ptr=5'h0F, w_ptr_sync=5'h11 -> reads addresses 15 then 0. r_ptr becomes 5'h10, then 5'h11; fifo_empty=1 afterwards.
- Full: r_ptr=0, w_ptr_sync=5'h10 -> fill_level=16, ptr_err=0, all 16 words delivered in order.
- Error and reset: r_ptr=0, w_ptr_sync=5'h14 -> ptr_err=1 next edge and no further fetches. Asserting reset mid-HOLD -> data_valid, r_ptr and ptr_err all 0 immediately.
